// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared widths and FSM state encoding for the data-memory arbiter
package dmem_arb_pkg;
  localparam int AW = 8;
  localparam int DW = 16;
  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester ports (pipeline, loader) and data-memory pins of the arbiter
interface dmem_arbiter_if;
  import dmem_arb_pkg::*;
  logic          req0, we0, gnt0, rvalid0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0, rdata0;
  logic          req1, we1, gnt1, rvalid1, lock1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1, rdata1;
  logic          mem_dwe;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, lock1, mem_rdata,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, mem_dwe, mem_addr, mem_wdata
  );
  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, lock1, mem_rdata,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, mem_dwe, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_starve_ctr.sv
// dmem_starve_ctr: 4-bit saturating count of cycles the loader was denied
module dmem_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  input  logic hold,
  output logic at_max
);
  localparam logic [3:0] L_MAX = 4'(MAX);
  logic [3:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (!hold) r_cnt <= clr ? 4'd0 : (inc && r_cnt != L_MAX) ? r_cnt + 4'd1 : r_cnt;
  end
  assign at_max = r_cnt == L_MAX;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: pipeline/loader data-memory arbiter with loader lock; DMEM_ARB_STARVE_EN enables the starvation guard
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  state_t        r_state, w_state_nx;
  logic          w_gnt0, w_gnt1, w_pri1;
  logic          r_rvalid0, r_rvalid1;
  logic [DW-1:0] r_rdata0, r_rdata1;
`ifdef DMEM_ARB_STARVE_EN
  logic w_at_max;
  dmem_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (bus.req1 & ~w_gnt1),
    .clr    (w_gnt1 | ~bus.req1),
    .hold   (r_state == LOCKED),
    .at_max (w_at_max)
  );
  assign w_pri1 = w_at_max & bus.req1;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = |STARVE_MAX;
  assign w_pri1 = 1'b0;
`endif
  // grants are masked during reset so nothing reaches the memory pins
  always_comb begin
    w_gnt0 = !rst && r_state == ARB && bus.req0 && !w_pri1;
    w_gnt1 = !rst && bus.req1 && (r_state == LOCKED || w_pri1 || !bus.req0);
    w_state_nx = r_state == LOCKED ? (bus.lock1 ? LOCKED : ARB) : (w_gnt1 && bus.lock1 ? LOCKED : ARB);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ARB;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_rvalid0 <= w_gnt0 && !bus.we0;
      r_rvalid1 <= w_gnt1 && !bus.we1;
      if (w_gnt0 && !bus.we0) r_rdata0 <= bus.mem_rdata;
      if (w_gnt1 && !bus.we1) r_rdata1 <= bus.mem_rdata;
    end
  end
  assign bus.gnt0      = w_gnt0;
  assign bus.gnt1      = w_gnt1;
  assign bus.rvalid0   = r_rvalid0;
  assign bus.rvalid1   = r_rvalid1;
  assign bus.rdata0    = r_rdata0;
  assign bus.rdata1    = r_rdata1;
  assign bus.mem_dwe   = (w_gnt0 & bus.we0) | (w_gnt1 & bus.we1);
  assign bus.mem_addr  = w_gnt1 ? bus.addr1 : bus.addr0;
  assign bus.mem_wdata = w_gnt1 ? bus.wdata1 : bus.wdata0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a 256x16 memory model
module tb_dmem_arbiter;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic [15:0] mem [256] = '{default: 16'h0};
  dmem_arbiter_if bus();
  dmem_arbiter #(.STARVE_MAX(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_dwe) mem[bus.mem_addr] <= bus.mem_wdata;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drv(input logic r0, input logic w0, input logic [7:0] a0, input logic [15:0] d0,
                     input logic r1, input logic w1, input logic [7:0] a1, input logic [15:0] d1,
                     input logic l1);
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    bus.lock1 = l1;
  endtask
  initial begin
    logic exp1;
    int n;
    rst = 1'b1;
    drv(1, 0, 8'h00, 16'h0, 1, 0, 8'h00, 16'h0, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_gnt1", bus.gnt1, 0);
    chk("rst_dwe", bus.mem_dwe, 0);
    chk("rst_rvalid0", bus.rvalid0, 0);
    chk("rst_rvalid1", bus.rvalid1, 0);
    chk("rst_rdata0", bus.rdata0, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_gnt0", bus.gnt0, 1);
    chk("post_rst_gnt1", bus.gnt1, 0);
    // port 0 write then read back
    @(negedge clk);
    drv(1, 1, 8'h10, 16'h00AB, 0, 0, 8'h00, 16'h0, 0);
    #1;
    chk("first_rd_rvalid0", bus.rvalid0, 1);
    chk("first_rd_rdata0", bus.rdata0, 16'h0000);
    chk("wr_gnt0", bus.gnt0, 1);
    chk("wr_dwe", bus.mem_dwe, 1);
    chk("wr_addr", bus.mem_addr, 16'h0010);
    chk("wr_wdata", bus.mem_wdata, 16'h00AB);
    @(negedge clk);
    drv(1, 0, 8'h10, 16'h0, 0, 0, 8'h00, 16'h0, 0);
    #1;
    chk("wr_no_rvalid0", bus.rvalid0, 0);
    chk("rd_gnt0", bus.gnt0, 1);
    chk("rd_dwe", bus.mem_dwe, 0);
    @(negedge clk);
    drv(1, 1, 8'h03, 16'h5A5A, 0, 0, 8'h00, 16'h0, 0);
    #1;
    chk("rd_rvalid0", bus.rvalid0, 1);
    chk("rd_rdata0", bus.rdata0, 16'h00AB);
    chk("wr3_dwe", bus.mem_dwe, 1);
    @(negedge clk);
    drv(0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0);
    #1;
    chk("idle_rvalid0", bus.rvalid0, 0);
    chk("hold_rdata0", bus.rdata0, 16'h00AB);
    // starvation: both ports held
    n = STARVE_ON ? 5 : 8;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      drv(1, 0, 8'h20, 16'h0, 1, 0, 8'h03, 16'h0, 0);
      #1;
      exp1 = STARVE_ON && i == 5;
      chk("starve_gnt1", bus.gnt1, exp1);
      chk("starve_gnt0", bus.gnt0, !exp1);
      chk("starve_addr", bus.mem_addr, exp1 ? 16'h0003 : 16'h0020);
    end
    @(negedge clk);
    drv(1, 0, 8'h20, 16'h0, 0, 0, 8'h00, 16'h0, 0);
    #1;
    chk("starve_rvalid1", bus.rvalid1, STARVE_ON);
    chk("starve_rdata1", bus.rdata1, STARVE_ON ? 16'h5A5A : 16'h0000);
    chk("resume_gnt0", bus.gnt0, 1);
    // loader lock
    @(negedge clk);
    drv(0, 0, 8'h00, 16'h0, 1, 1, 8'h40, 16'hBEEF, 1);
    #1;
    chk("lk_gnt1", bus.gnt1, 1);
    chk("lk_gnt0", bus.gnt0, 0);
    chk("lk_dwe", bus.mem_dwe, 1);
    chk("lk_addr", bus.mem_addr, 16'h0040);
    @(negedge clk);
    drv(1, 0, 8'h10, 16'h0, 1, 1, 8'h41, 16'hCAFE, 1);
    #1;
    chk("lk_c1_gnt0", bus.gnt0, 0);
    chk("lk_c1_gnt1", bus.gnt1, 1);
    chk("lk_c1_wdata", bus.mem_wdata, 16'hCAFE);
    repeat (2) begin
      @(negedge clk);
      drv(1, 0, 8'h10, 16'h0, 0, 0, 8'h00, 16'h0, 1);
      #1;
      chk("lk_idle_gnt0", bus.gnt0, 0);
      chk("lk_idle_gnt1", bus.gnt1, 0);
    end
    @(negedge clk);
    drv(1, 0, 8'h41, 16'h0, 0, 0, 8'h00, 16'h0, 0);
    #1;
    chk("lk_rel_gnt0", bus.gnt0, 0);
    @(negedge clk);
    #1;
    chk("unlk_gnt0", bus.gnt0, 1);
    @(negedge clk);
    drv(0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0);
    #1;
    chk("unlk_rvalid0", bus.rvalid0, 1);
    chk("unlk_rdata0", bus.rdata0, 16'hCAFE);
    // same-address write vs read
    @(negedge clk);
    drv(1, 1, 8'h07, 16'h1234, 1, 0, 8'h07, 16'h0, 0);
    #1;
    chk("coll_gnt0", bus.gnt0, 1);
    chk("coll_gnt1", bus.gnt1, 0);
    @(negedge clk);
    drv(0, 0, 8'h00, 16'h0, 1, 0, 8'h07, 16'h0, 0);
    #1;
    chk("coll_later_gnt1", bus.gnt1, 1);
    chk("coll_later_addr", bus.mem_addr, 16'h0007);
    @(negedge clk);
    drv(0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0);
    #1;
    chk("coll_rvalid1", bus.rvalid1, 1);
    chk("coll_rdata1", bus.rdata1, 16'h1234);
    // reset while locked with a read in flight
    @(negedge clk);
    drv(0, 0, 8'h00, 16'h0, 1, 0, 8'h40, 16'h0, 1);
    #1;
    chk("rl_gnt1", bus.gnt1, 1);
    @(negedge clk);
    drv(1, 0, 8'h10, 16'h0, 1, 0, 8'h40, 16'h0, 1);
    #1;
    chk("rl_rvalid1", bus.rvalid1, 1);
    chk("rl_rdata1", bus.rdata1, 16'hBEEF);
    chk("rl_locked_gnt0", bus.gnt0, 0);
    chk("rl_locked_gnt1", bus.gnt1, 1);
    rst = 1'b1;
    #1;
    chk("rl_rst_gnt1", bus.gnt1, 0);
    chk("rl_rst_dwe", bus.mem_dwe, 0);
    @(negedge clk);
    #1;
    chk("rl_drop_rvalid1", bus.rvalid1, 0);
    chk("rl_rst_rdata1", bus.rdata1, 16'h0000);
    rst = 1'b0;
    #1;
    chk("rl_arb_gnt0", bus.gnt0, 1);
    chk("rl_arb_gnt1", bus.gnt1, 0);
    @(negedge clk);
    drv(0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0);
    #1;
    chk("rl_rvalid0", bus.rvalid0, 1);
    chk("rl_rdata0", bus.rdata0, 16'h00AB);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
